// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse controller: oversampled frame receiver, 3-byte packet assembler,
// clamped absolute position and a four-register read port on the CPU bus.
module ps2_mouse_ctrl #(
    parameter logic [63:0] BASE_ADDR      = 64'h2250,
    parameter int unsigned POS_WIDTH      = 16,
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned Y_MAX          = 479,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mouse_clk,
    input  logic        mouse_signal,
    input  logic        read,
    input  logic [63:0] address,
    output logic [63:0] data
);

    localparam int unsigned EW   = POS_WIDTH + 2;
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [POS_WIDTH-1:0] X_LIM = POS_WIDTH'(X_MAX);
    localparam logic [POS_WIDTH-1:0] Y_LIM = POS_WIDTH'(Y_MAX);
    localparam logic [WD_W-1:0]      WD_END = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    // Input conditioning
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic clk_prev_q, clk_prev_d, fall_q, fall_d, bit_q, bit_d;

    // Frame receiver
    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;

    // Packet assembler and user-visible state
    logic [1:0]           idx_q, idx_d;
    logic [6:0]           hdr_q, hdr_d;
    logic [7:0]           b1_q, b1_d;
    logic [POS_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [2:0]           btn_q, btn_d;
    logic                 new_data_q, new_data_d;
    logic [15:0]          pkt_cnt_q, pkt_cnt_d;
    logic [7:0]           ferr_cnt_q, ferr_cnt_d, serr_cnt_q, serr_cnt_d;

    logic [63:0] off_c, rdata_c;
    logic        hit_c, clr_c;

    // Adds a 9-bit signed delta and clamps to 0..lim, computed in EW signed bits
    function automatic logic [POS_WIDTH-1:0] clamp_add(
        input logic [POS_WIDTH-1:0] pos,
        input logic                 sgn,
        input logic [7:0]           mag,
        input logic [POS_WIDTH-1:0] lim
    );
        logic signed [EW-1:0] sum;
        logic signed [EW-1:0] delta;
        logic signed [EW-1:0] lim_s;
        delta = {{(EW-9){sgn}}, sgn, mag};
        sum   = $signed({2'b00, pos}) + delta;
        lim_s = $signed({2'b00, lim});
        if (sum[EW-1])
            return '0;
        else if (sum > lim_s)
            return lim;
        else
            return sum[POS_WIDTH-1:0];
    endfunction

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], mouse_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], mouse_signal};
        clk_prev_d = clk_sync_q[SYNC_STAGES-1];
        fall_d     = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        bit_d      = dat_sync_q[SYNC_STAGES-1];
    end

    // Frame FSM next-state with mid-frame watchdog
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        wd_d         = '0;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (state_q != IDLE)
            wd_d = fall_q ? '0 : wd_q + WD_W'(1);
        unique case (state_q)
            IDLE: if (fall_q && !bit_q) begin
                state_d   = DATA;
                bit_cnt_d = 3'd0;
            end
            DATA: if (fall_q) begin
                shift_d   = {bit_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7)
                    state_d = PARITY;
            end
            PARITY: if (fall_q) begin
                par_d   = bit_q;
                state_d = STOP;
            end
            STOP: if (fall_q) begin
                if (bit_q && (^{shift_q, par_q}))
                    byte_valid_d = 1'b1;
                else
                    frame_err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && !fall_q && (wd_q == WD_END)) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            wd_d        = '0;
        end
    end

    assign clr_c = read && (address == BASE_ADDR);

    // Packet assembly, position update and counters
    always_comb begin
        idx_d      = idx_q;
        hdr_d      = hdr_q;
        b1_d       = b1_q;
        x_d        = x_q;
        y_d        = y_q;
        btn_d      = btn_q;
        pkt_cnt_d  = pkt_cnt_q;
        ferr_cnt_d = ferr_cnt_q;
        serr_cnt_d = serr_cnt_q;
        new_data_d = clr_c ? 1'b0 : new_data_q;
        if (frame_err_q) begin
            idx_d = 2'd0;
            if (ferr_cnt_q != 8'hFF)
                ferr_cnt_d = ferr_cnt_q + 8'd1;
        end else if (byte_valid_q) begin
            unique case (idx_q)
                2'd0: begin
                    if (shift_q[3]) begin
                        hdr_d = {shift_q[7:4], shift_q[2:0]};
                        idx_d = 2'd1;
                    end else if (serr_cnt_q != 8'hFF) begin
                        serr_cnt_d = serr_cnt_q + 8'd1;
                    end
                end
                2'd1: begin
                    b1_d  = shift_q;
                    idx_d = 2'd2;
                end
                default: begin
                    idx_d = 2'd0;
                    // hdr_q = {Yovf, Xovf, Ysign, Xsign, M, R, L}
                    if (!hdr_q[5])
                        x_d = clamp_add(x_q, hdr_q[3], b1_q, X_LIM);
                    if (!hdr_q[6])
                        y_d = clamp_add(y_q, hdr_q[4], shift_q, Y_LIM);
                    btn_d      = hdr_q[2:0];
                    new_data_d = 1'b1;
                    pkt_cnt_d  = pkt_cnt_q + 16'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_q   <= '0;
            dat_sync_q   <= '0;
            clk_prev_q   <= 1'b0;
            fall_q       <= 1'b0;
            bit_q        <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            wd_q         <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            idx_q        <= '0;
            hdr_q        <= '0;
            b1_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            btn_q        <= '0;
            new_data_q   <= 1'b0;
            pkt_cnt_q    <= '0;
            ferr_cnt_q   <= '0;
            serr_cnt_q   <= '0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            clk_prev_q   <= clk_prev_d;
            fall_q       <= fall_d;
            bit_q        <= bit_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            wd_q         <= wd_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            idx_q        <= idx_d;
            hdr_q        <= hdr_d;
            b1_q         <= b1_d;
            x_q          <= x_d;
            y_q          <= y_d;
            btn_q        <= btn_d;
            new_data_q   <= new_data_d;
            pkt_cnt_q    <= pkt_cnt_d;
            ferr_cnt_q   <= ferr_cnt_d;
            serr_cnt_q   <= serr_cnt_d;
        end
    end

    // Combinational read port
    always_comb begin
        off_c   = address - BASE_ADDR;
        hit_c   = read && (off_c < 64'd4);
        rdata_c = '0;
        unique case (off_c[1:0])
            2'd0:    rdata_c[4:0]  = {state_q != IDLE, new_data_q, btn_q};
            2'd1:    rdata_c       = 64'(x_q);
            2'd2:    rdata_c       = 64'(y_q);
            default: rdata_c[31:0] = {serr_cnt_q, ferr_cnt_q, pkt_cnt_q};
        endcase
    end

    assign data = hit_c ? rdata_c : {64{1'bz}};

endmodule
